// File: rtl/tinyriscv_pkg.sv
// Shared core types: register bus/address widths and register file debug FSM states.
package tinyriscv_pkg;

   localparam int RegNum     = 32;
   localparam int RegNumLog2 = 5;

   typedef logic [31:0]           RegBus;
   typedef logic [RegNumLog2-1:0] RegAddrBus;
   typedef RegAddrBus             reg_addr_t;

   typedef enum logic {
      DBG_IDLE,
      DBG_RESP
   } dbg_state_e;

endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves all writeback ports against one register address; highest enabled port index wins.
module regfile_wr_arb #(
   parameter int NR_WRITE = 2,
   parameter int DATA_W   = 32,
   parameter int AW       = 5
) (
   input  logic [NR_WRITE-1:0]             we,
   input  logic [NR_WRITE-1:0][AW-1:0]     waddr,
   input  logic [NR_WRITE-1:0][DATA_W-1:0] wdata,
   input  logic [AW-1:0]                   addr,
   output logic                            hit,
   output logic [DATA_W-1:0]               data
);

   // Ascending scan: a later (higher-index) match overrides earlier ones.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int p = 0; p < NR_WRITE; p++) begin
         if (we[p] && (waddr[p] == addr)) begin
            hit  = 1'b1;
            data = wdata[p];
         end
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with pending-write scoreboard and handshaked debug access.
module regfile_mp_sb
   import tinyriscv_pkg::*;
#(
   parameter  int NR_READ    = 2,
   parameter  int NR_WRITE   = 2,
   parameter  int DATA_W     = $bits(RegBus),
   parameter  int NR_REGS    = RegNum,
   parameter  int BYPASS     = 1,
   parameter  int STARVE_LIM = 8,
   localparam int AW         = $clog2(NR_REGS)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NR_WRITE-1:0]             we_i,
   input  logic [NR_WRITE-1:0][AW-1:0]     waddr_i,
   input  logic [NR_WRITE-1:0][DATA_W-1:0] wdata_i,
   input  logic [NR_READ-1:0][AW-1:0]      raddr_i,
   output logic [NR_READ-1:0][DATA_W-1:0]  rdata_o,
   output logic [NR_READ-1:0]              rbusy_o,
   input  logic                            sb_set_i,
   input  logic [AW-1:0]                   sb_addr_i,
   output logic [NR_REGS-1:0]              pending_o,
   output logic                            sb_err_o,
   input  logic                            dbg_req_i,
   input  logic                            dbg_we_i,
   input  logic [AW-1:0]                   dbg_addr_i,
   input  logic [DATA_W-1:0]               dbg_wdata_i,
   output logic                            dbg_gnt_o,
   output logic                            dbg_rvalid_o,
   output logic [DATA_W-1:0]               dbg_rdata_o,
   output logic                            dbg_stall_req_o
);

   localparam int CW = $clog2(STARVE_LIM + 1);

   logic [NR_REGS-1:0][DATA_W-1:0] regs;
   logic [NR_REGS-1:0]             wr_hit;
   logic [NR_REGS-1:0][DATA_W-1:0] wr_data;
   dbg_state_e                     state_q, state_d;
   logic                           dbg_gnt;
   logic [CW-1:0]                  starve_q, starve_d;

   // One resolver per register feeds both the array write and the read bypass.
   for (genvar r = 0; r < NR_REGS; r++) begin : g_arb
      regfile_wr_arb #(
         .NR_WRITE(NR_WRITE),
         .DATA_W  (DATA_W),
         .AW      (AW)
      ) u_arb (
         .we   (we_i),
         .waddr(waddr_i),
         .wdata(wdata_i),
         .addr (AW'(r)),
         .hit  (wr_hit[r]),
         .data (wr_data[r])
      );
   end

   always_comb begin
      for (int p = 0; p < NR_READ; p++) begin
         rdata_o[p] = regs[raddr_i[p]];
         if ((BYPASS != 0) && wr_hit[raddr_i[p]])
            rdata_o[p] = wr_data[raddr_i[p]];
         if (raddr_i[p] == '0)
            rdata_o[p] = '0;
         rbusy_o[p] = pending_o[raddr_i[p]];
      end
   end

   // Debug writes only happen with no core write active, so they never collide.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         regs <= '0;
      end else begin
         for (int r = 1; r < NR_REGS; r++)
            if (wr_hit[r]) regs[r] <= wr_data[r];
         if (dbg_gnt && dbg_we_i && (dbg_addr_i != '0))
            regs[dbg_addr_i] <= dbg_wdata_i;
      end
   end

   // Issue beats writeback-clear on the same register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_o <= '0;
         sb_err_o  <= 1'b0;
      end else begin
         for (int r = 1; r < NR_REGS; r++) begin
            if (sb_set_i && (sb_addr_i == AW'(r)))
               pending_o[r] <= 1'b1;
            else if (wr_hit[r])
               pending_o[r] <= 1'b0;
         end
         if (sb_set_i && (sb_addr_i != '0) && pending_o[sb_addr_i])
            sb_err_o <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      dbg_gnt = 1'b0;
      case (state_q)
         DBG_IDLE: begin
            if (dbg_req_i && (we_i == '0) && !pending_o[dbg_addr_i]) begin
               dbg_gnt = 1'b1;
               state_d = DBG_RESP;
            end
         end
         DBG_RESP: state_d = DBG_IDLE;
         default:  state_d = DBG_IDLE;
      endcase
   end

   // Starvation only accrues while idle and denied; RESP cycles hold the count.
   always_comb begin
      starve_d = starve_q;
      if (!dbg_req_i || dbg_gnt)
         starve_d = '0;
      else if ((state_q == DBG_IDLE) && (starve_q != CW'(STARVE_LIM)))
         starve_d = starve_q + 1'b1;
   end

   assign dbg_gnt_o = dbg_gnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= DBG_IDLE;
         dbg_rvalid_o    <= 1'b0;
         dbg_rdata_o     <= '0;
         starve_q        <= '0;
         dbg_stall_req_o <= 1'b0;
      end else begin
         state_q         <= state_d;
         dbg_rvalid_o    <= dbg_gnt;
         if (dbg_gnt)
            dbg_rdata_o <= dbg_we_i ? '0 : regs[dbg_addr_i];
         starve_q        <= starve_d;
         dbg_stall_req_o <= (starve_d == CW'(STARVE_LIM));
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed + randomized bench for regfile_mp_sb against an array/flag reference model.
module tb_regfile_mp_sb;

   localparam int NR_READ  = 2;
   localparam int NR_WRITE = 2;
   localparam int DATA_W   = 32;
   localparam int NR_REGS  = 32;
   localparam int AW       = 5;
   localparam int LIM      = 8;

   logic                            clk = 1'b0;
   logic                            rst;
   logic [NR_WRITE-1:0]             we;
   logic [NR_WRITE-1:0][AW-1:0]     waddr;
   logic [NR_WRITE-1:0][DATA_W-1:0] wdata;
   logic [NR_READ-1:0][AW-1:0]      raddr;
   logic [NR_READ-1:0][DATA_W-1:0]  rdata;
   logic [NR_READ-1:0]              rbusy;
   logic                            sb_set;
   logic [AW-1:0]                   sb_addr;
   logic [NR_REGS-1:0]              pending;
   logic                            sb_err;
   logic                            dbg_req, dbg_we;
   logic [AW-1:0]                   dbg_addr;
   logic [DATA_W-1:0]               dbg_wdata, dbg_rdata;
   logic                            dbg_gnt, dbg_rvalid, dbg_stall;

   always #5 clk = ~clk;

   regfile_mp_sb #(
      .NR_READ(NR_READ), .NR_WRITE(NR_WRITE), .DATA_W(DATA_W),
      .NR_REGS(NR_REGS), .BYPASS(1), .STARVE_LIM(LIM)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
      .sb_set_i(sb_set), .sb_addr_i(sb_addr), .pending_o(pending), .sb_err_o(sb_err),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
      .dbg_stall_req_o(dbg_stall)
   );

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] m_reg [NR_REGS];
   bit                m_pend [NR_REGS];
   bit                m_err, m_resp, m_rvalid, m_stall;
   int                m_starve;
   logic [DATA_W-1:0] m_drdata;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NR_REGS; r++) begin
         m_reg[r]  = '0;
         m_pend[r] = 1'b0;
      end
      m_err = 0; m_resp = 0; m_rvalid = 0; m_stall = 0; m_starve = 0; m_drdata = '0;
   endtask

   function automatic logic [DATA_W-1:0] exp_read(input logic [AW-1:0] a);
      logic [DATA_W-1:0] v;
      if (a == 0) return '0;
      v = m_reg[a];
      for (int p = 0; p < NR_WRITE; p++)
         if (we[p] && waddr[p] == a) v = wdata[p];
      return v;
   endfunction

   function automatic bit exp_gnt();
      return !m_resp && dbg_req && (we == 0) && !m_pend[dbg_addr];
   endfunction

   task automatic at_neg();
      logic [NR_REGS-1:0] pv;
      @(negedge clk);
      for (int p = 0; p < NR_READ; p++) begin
         chk($sformatf("rdata%0d@%0d", p, raddr[p]), rdata[p], exp_read(raddr[p]));
         chk($sformatf("rbusy%0d@%0d", p, raddr[p]), rbusy[p], m_pend[raddr[p]]);
      end
      for (int r = 0; r < NR_REGS; r++) pv[r] = m_pend[r];
      chk("pending", pending, pv);
      chk("sb_err", sb_err, m_err);
      chk("dbg_gnt", dbg_gnt, exp_gnt());
      chk("dbg_rvalid", dbg_rvalid, m_rvalid);
      chk("dbg_rdata", dbg_rdata, m_drdata);
      chk("dbg_stall", dbg_stall, m_stall);
   endtask

   task automatic at_pos();
      bit g, resp_old;
      g = exp_gnt();
      resp_old = m_resp;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (sb_set && sb_addr != 0 && m_pend[sb_addr]) m_err = 1;
         for (int p = 0; p < NR_WRITE; p++)
            if (we[p] && waddr[p] != 0) m_pend[waddr[p]] = 0;
         if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1;
         if (g) m_drdata = dbg_we ? '0 : m_reg[dbg_addr];
         for (int p = 0; p < NR_WRITE; p++)
            if (we[p] && waddr[p] != 0) m_reg[waddr[p]] = wdata[p];
         if (g && dbg_we && dbg_addr != 0) m_reg[dbg_addr] = dbg_wdata;
         m_rvalid = g;
         m_resp   = g;
         if (!dbg_req || g) m_starve = 0;
         else if (!resp_old && m_starve < LIM) m_starve++;
         m_stall = (m_starve == LIM);
      end
      #1;
   endtask

   initial begin
      rst = 1; we = '0; waddr = '0; wdata = '0; raddr = '0; sb_set = 0; sb_addr = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 0;

      // 1: reset state on every register, both ports
      for (int a = 0; a < NR_REGS; a++) begin
         raddr[0] = AW'(a);
         raddr[1] = AW'(NR_REGS - 1 - a);
         at_neg();
         chk("t1_rd0", rdata[0], '0);
         chk("t1_rd1", rdata[1], '0);
         at_pos();
      end
      at_neg();
      chk("t1_pending", pending, '0);
      chk("t1_rvalid", dbg_rvalid, '0);
      at_pos();

      // 2: same-address dual write, higher port wins
      we = 2'b11; waddr[0] = 5; waddr[1] = 5; wdata[0] = 32'hAAAA; wdata[1] = 32'h5555; raddr[0] = 5;
      at_neg(); chk("t2_bypass", rdata[0], 32'h5555); at_pos();
      we = '0;
      at_neg(); chk("t2_array", rdata[0], 32'h5555); at_pos();

      // 3: scoreboard set, set-beats-clear, double set error
      sb_set = 1; sb_addr = 7;
      at_neg(); at_pos();
      sb_set = 0; raddr[1] = 7;
      at_neg(); chk("t3_pend7", pending[7], 1'b1); chk("t3_rbusy", rbusy[1], 1'b1); at_pos();
      we = 2'b01; waddr[0] = 7; wdata[0] = 32'h77; sb_set = 1;
      at_neg(); at_pos();
      we = '0;
      at_neg(); chk("t3_setwins", pending[7], 1'b1); at_pos();
      sb_set = 0;
      at_neg(); chk("t3_sb_err", sb_err, 1'b1); at_pos();

      // 4: debug read of reg 3
      we = 2'b01; waddr[0] = 3; wdata[0] = 32'h1234;
      at_neg(); at_pos();
      we = '0; dbg_req = 1; dbg_we = 0; dbg_addr = 3;
      at_neg(); chk("t4_gnt", dbg_gnt, 1'b1); at_pos();
      dbg_req = 0;
      at_neg(); chk("t4_rvalid", dbg_rvalid, 1'b1); chk("t4_rdata", dbg_rdata, 32'h1234); at_pos();
      at_neg(); chk("t4_rvalid_1cyc", dbg_rvalid, 1'b0); at_pos();

      // 5: debug write starved by 10 cycles of writeback
      dbg_req = 1; dbg_we = 1; dbg_addr = 9; dbg_wdata = 32'hCAFE;
      for (int i = 0; i < 10; i++) begin
         we = 2'b01; waddr[0] = AW'(10 + i); wdata[0] = $urandom;
         at_neg();
         chk($sformatf("t5_nognt%0d", i), dbg_gnt, 1'b0);
         chk($sformatf("t5_stall%0d", i), dbg_stall, (i >= 8) ? 1'b1 : 1'b0);
         at_pos();
      end
      we = '0;
      at_neg(); chk("t5_gnt", dbg_gnt, 1'b1); chk("t5_stall_hold", dbg_stall, 1'b1); at_pos();
      dbg_req = 0; raddr[0] = 9;
      at_neg();
      chk("t5_stall_drop", dbg_stall, 1'b0);
      chk("t5_wack", dbg_rdata, '0);
      chk("t5_reg9", rdata[0], 32'hCAFE);
      at_pos();

      // 6: debug write to x0, then reset during a granted access
      dbg_req = 1; dbg_we = 1; dbg_addr = 0; dbg_wdata = 32'hFFFF;
      at_neg(); chk("t6_gnt", dbg_gnt, 1'b1); at_pos();
      dbg_req = 0; raddr[0] = 0;
      at_neg(); chk("t6_ack", dbg_rvalid, 1'b1); chk("t6_x0", rdata[0], '0); at_pos();
      dbg_req = 1; dbg_we = 0; dbg_addr = 3;
      at_neg(); chk("t6_gnt2", dbg_gnt, 1'b1);
      rst = 1;
      at_pos();
      dbg_req = 0;
      at_neg(); chk("t6_rst_norvalid", dbg_rvalid, 1'b0);
      rst = 0;
      at_pos();
      at_neg(); chk("t6_rst_norvalid2", dbg_rvalid, 1'b0); at_pos();

      // randomized traffic, checked every cycle by at_neg
      for (int c = 0; c < 400; c++) begin
         we = ($urandom_range(0, 1) != 0) ? NR_WRITE'($urandom) : '0;
         for (int p = 0; p < NR_WRITE; p++) begin
            waddr[p] = AW'($urandom_range(0, 7));
            wdata[p] = $urandom;
         end
         for (int p = 0; p < NR_READ; p++) raddr[p] = AW'($urandom_range(0, 9));
         sb_set    = ($urandom_range(0, 3) == 0);
         sb_addr   = AW'($urandom_range(0, 7));
         dbg_req   = ($urandom_range(0, 1) != 0);
         dbg_we    = ($urandom_range(0, 1) != 0);
         dbg_addr  = AW'($urandom_range(0, 9));
         dbg_wdata = $urandom;
         rst       = (c % 97 == 50);
         at_neg();
         at_pos();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
